// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rxd, mid-bit sampling, LSB-first frames, one-cycle result strobes.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx #(
   parameter int CLK_FRE   = 50_000_000,
   parameter int BAUD_RATE = 9600,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int BPS_CNT = CLK_FRE / BAUD_RATE - 1;
   localparam int HALF    = BPS_CNT / 2;
   localparam int CNT_W   = $clog2(BPS_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BPS_CNT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state_q, state_d;
   logic [1:0]           sync_q, sync_d;
   logic                 prev_q, prev_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_d;
   logic                 rxd_s;
   logic                 tick;

`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 perr_q;
`endif

   assign rxd_s = sync_q[1];
   assign tick  = (cnt_q == CNT_MAX);

   always_comb begin
      sync_d  = {sync_q[0], rxd};
      prev_d  = rxd_s;
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         IDLE: if (prev_q && !rxd_s) state_d = START;
         START: if (cnt_q == CNT_HALF) begin
            state_d = rxd_s ? IDLE : DATA;
            idx_d   = '0;
         end
         DATA: if (tick) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (tick) begin
            par_d   = rxd_s;
            state_d = STOP;
         end
`endif
         STOP: if (tick) begin
            state_d = IDLE;
            if (!rxd_s) begin
               ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift_q, par_q}) begin
               perr_d = 1'b1;
`endif
            end else begin
               valid_d = 1'b1;
               data_d  = shift_q;
            end
         end
         default: state_d = IDLE;
      endcase
      // Counter restarts on every state transition so each phase measures from its own entry.
      if (state_q == IDLE || state_d != state_q || tick) cnt_d = '0;
      else                                              cnt_d = cnt_q + CNT_W'(1);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sync_q  <= '1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign rx_busy   = busy_q;
   assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = perr_d & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are modelled byte-wise, a monitor pops expected events on each strobe.
module tb_uart_rx;
   localparam int CLK_FRE = 1_000_000;
   localparam int BAUD    = 100_000;
   localparam int BIT     = CLK_FRE / BAUD;
   localparam int EV_VALID = 0, EV_FERR = 1, EV_PERR = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_busy, frame_err, parity_err;

   uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .DATA_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_busy(rx_busy), .frame_err(frame_err), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   typedef struct { int kind; logic [7:0] data; } exp_t;
   exp_t       sb[$];
   logic [7:0] last_data;
   int         checks = 0;
   int         passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: a frame yields valid(byte) when stop is high and parity holds, else an error carrying last good byte.
   task automatic expect_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
      exp_t e;
      bit par_ok;
`ifdef UART_RX_PARITY_EN
      par_ok = !par_flip;
`else
      par_ok = 1'b1 | par_flip;
`endif
      if (!stop_ok)     e = '{EV_FERR, last_data};
      else if (!par_ok) e = '{EV_PERR, last_data};
      else begin
         last_data = b;
         e = '{EV_VALID, b};
      end
      sb.push_back(e);
   endtask

   task automatic bit_out(input logic b);
      rxd = b;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bit_out(1'b1);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
      bit_out((^b) ^ par_flip);
`endif
      bit_out(stop_ok);
   endtask

   task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_flip);
      expect_frame(b, stop_ok, par_flip);
      send_frame(b, stop_ok, par_flip);
   endtask

   always @(negedge clk) begin
      int   kind;
      exp_t e;
      if (rst_n && (rx_valid || frame_err || parity_err)) begin
         kind = rx_valid ? EV_VALID : (frame_err ? EV_FERR : EV_PERR);
         check("pulse_exclusive", int'(rx_valid) + int'(frame_err) + int'(parity_err), 1);
         check("event_expected", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("rx_data", rx_data, e.data);
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rx_data"},    rx_data, 0);
      check({tag, "_rx_valid"},   rx_valid, 0);
      check({tag, "_rx_busy"},    rx_busy, 0);
      check({tag, "_frame_err"},  frame_err, 0);
      check({tag, "_parity_err"}, parity_err, 0);
   endtask

   initial begin
      logic [7:0] b;
      bit         stop_ok, flip;
      last_data = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      send(8'hA5, 1'b1, 1'b0);
      idle(1);
      @(negedge clk);
      check("busy_after_a5", rx_busy, 0);
      check("drained_a5", sb.size(), 0);
      @(posedge clk); #1;

      send(8'h00, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b0);
      send(8'h55, 1'b1, 1'b0);
      idle(2);
      check("drained_b2b", sb.size(), 0);

      rxd = 1'b0;
      repeat (2) @(posedge clk); #1;
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      check("busy_in_glitch", rx_busy, 1);
      @(posedge clk); #1;
      idle(3);
      check("busy_after_glitch", rx_busy, 0);
      check("drained_glitch", sb.size(), 0);

      send(8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) bit_out(1'b0);
      idle(1);
      send(8'h11, 1'b1, 1'b0);
      idle(2);
      check("drained_break", sb.size(), 0);

      b = 8'hC3;
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(b[i]);
      rxd = b[4];
      repeat (BIT / 2) @(posedge clk); #1;
      rst_n = 1'b0;
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs_zero("midreset");
      last_data = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      send(8'h81, 1'b1, 1'b0);
      idle(2);
      check("drained_reset", sb.size(), 0);

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b0);
      idle(1);
      send(8'h07, 1'b1, 1'b1);
      idle(1);
      send(8'h5A, 1'b0, 1'b1);
      idle(2);
      check("drained_parity", sb.size(), 0);
`endif

      for (int n = 0; n < 24; n++) begin
         b       = 8'($urandom);
         stop_ok = ($urandom_range(0, 7) != 0);
         flip    = ($urandom_range(0, 3) == 0);
         send(b, stop_ok, flip);
         // A low stop bit needs a high gap, otherwise the next start bit has no falling edge.
         idle(stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2));
      end
      idle(3);
      check("drained_random", sb.size(), 0);
      check("busy_final", rx_busy, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
